fifo_drain_ser: RTL and testbench

//   Read-side consumer for the 16-bit synchronous FIFO. Pops one word at a time

---
 rtl/fifo_drain_ser_if.sv | 25 ++
 rtl/fifo_drain_ser.sv | 116 +++++++++++
 tb/tb_fifo_drain_ser.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_drain_ser_if.sv
// Handshake bundle between the FIFO read port, the drain serializer and the serial link.
// master = serializer side, slave = FIFO/link environment side.
interface fifo_drain_ser_if #(
  parameter int WIDTH = 16
);
  logic             en;
  logic             emptyp;
  logic [WIDTH-1:0] fifo_dout;
  logic             readp;
  logic             ser_out;
  logic             ser_valid;
  logic             frame_start;
  logic             busy;
  logic [15:0]      words_sent;

  modport master (
    input  en, emptyp, fifo_dout,
    output readp, ser_out, ser_valid, frame_start, busy, words_sent
  );

  modport slave (
    output en, emptyp, fifo_dout,
    input  readp, ser_out, ser_valid, frame_start, busy, words_sent
  );
endinterface

// File: rtl/fifo_drain_ser.sv
// Pops words from a 1-cycle-latency synchronous FIFO and shifts them out MSB-first
// on a serial stream with valid/frame markers, optional even parity and idle gap.
module fifo_drain_ser #(
  parameter int WIDTH  = 16,
  parameter int GAP    = 0,
  parameter int PARITY = 0
) (
  input  logic             clk,
  input  logic             rstn,
  fifo_drain_ser_if.master bus
);
  localparam int              LEN       = WIDTH + PARITY;
  localparam int              CW        = $clog2(LEN + 1);
  localparam logic [CW-1:0]   LAST_BIT  = CW'(LEN - 1);
  localparam logic [CW-1:0]   LAST_DATA = CW'(WIDTH - 1);
  localparam logic [3:0]      GAP_LAST  = 4'(GAP - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_LOAD,
    ST_SHIFT,
    ST_GAP
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [CW-1:0]    bitcnt_q;
  logic [3:0]       gapcnt_q;
  logic             parity_q;
  logic             readp_q;
  logic             ser_out_q;
  logic             ser_valid_q;
  logic             frame_start_q;
  logic             busy_q;
  logic [15:0]      words_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      shreg_q       <= '0;
      bitcnt_q      <= '0;
      gapcnt_q      <= '0;
      parity_q      <= 1'b0;
      readp_q       <= 1'b0;
      ser_out_q     <= 1'b0;
      ser_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
      words_q       <= '0;
    end else begin
      readp_q       <= 1'b0;
      frame_start_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.en && !bus.emptyp) begin
            state_q <= ST_REQ;
            readp_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ST_REQ: begin
          state_q <= ST_LOAD;
        end
        // Outputs are registered, so the MSB is presented directly from fifo_dout here.
        ST_LOAD: begin
          shreg_q       <= bus.fifo_dout;
          bitcnt_q      <= '0;
          parity_q      <= ^bus.fifo_dout;
          ser_valid_q   <= 1'b1;
          ser_out_q     <= bus.fifo_dout[WIDTH-1];
          frame_start_q <= 1'b1;
          state_q       <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (bitcnt_q == LAST_BIT) begin
            words_q     <= words_q + 16'd1;
            ser_valid_q <= 1'b0;
            ser_out_q   <= 1'b0;
            gapcnt_q    <= '0;
            if (GAP > 0) begin
              state_q <= ST_GAP;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            bitcnt_q  <= bitcnt_q + CW'(1);
            shreg_q   <= shreg_q << 1;
            ser_out_q <= (bitcnt_q < LAST_DATA) ? shreg_q[WIDTH-2] : parity_q;
          end
        end
        ST_GAP: begin
          if (gapcnt_q == GAP_LAST) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            gapcnt_q <= gapcnt_q + 4'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.readp       = readp_q;
  assign bus.ser_out     = ser_out_q;
  assign bus.ser_valid   = ser_valid_q;
  assign bus.frame_start = frame_start_q;
  assign bus.busy        = busy_q;
  assign bus.words_sent  = words_q;

endmodule

// File: tb/tb_fifo_drain_ser.sv
// Two drains (plain, and GAP=2 with parity) fed by queue-based FIFO models;
// a per-bit scoreboard deserializes each stream against the words pushed.
module tb_fifo_drain_ser;
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  fifo_drain_ser_if #(.WIDTH(16)) if0 ();
  fifo_drain_ser_if #(.WIDTH(16)) if1 ();

  fifo_drain_ser #(.WIDTH(16), .GAP(0), .PARITY(0)) u_dut0 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (if0)
  );

  fifo_drain_ser #(.WIDTH(16), .GAP(2), .PARITY(1)) u_dut1 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (if1)
  );

  int          n_total = 0;
  int          n_bad   = 0;
  logic [15:0] fq0[$];
  logic [15:0] fq1[$];
  logic [15:0] exp0[$];
  logic [15:0] exp1[$];
  int          idx[2];
  logic [15:0] cur[2];
  int          lowrun[2];
  int          lastgap[2];
  int          ws_exp[2];
  int          rp_cnt[2];
  logic        lastbit[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic mon_reset();
    for (int d = 0; d < 2; d++) begin
      idx[d]     = 0;
      cur[d]     = '0;
      lowrun[d]  = 0;
      lastgap[d] = 0;
      ws_exp[d]  = 0;
      rp_cnt[d]  = 0;
      lastbit[d] = 1'b0;
    end
  endtask

  task automatic fifo_svc();
    if (if0.readp) begin
      rp_cnt[0]++;
      chk("pop_nonempty0", 32'(fq0.size() != 0), 32'd1);
      if (fq0.size() != 0) if0.fifo_dout = fq0.pop_front();
      if0.emptyp = (fq0.size() == 0);
    end
    if (if1.readp) begin
      rp_cnt[1]++;
      chk("pop_nonempty1", 32'(fq1.size() != 0), 32'd1);
      if (fq1.size() != 0) if1.fifo_dout = fq1.pop_front();
      if1.emptyp = (fq1.size() == 0);
    end
  endtask

  task automatic mon(input int d, input logic sv, input logic so, input logic fs,
                     input logic [15:0] ws);
    int   len;
    logic eb;
    len = (d == 0) ? 16 : 17;
    chk($sformatf("words_sent%0d", d), 32'(ws), ws_exp[d]);
    if (sv) begin
      if (idx[d] == 0) begin
        lastgap[d] = lowrun[d];
        if (d == 0) begin
          chk("word_expected0", 32'(exp0.size() != 0), 32'd1);
          if (exp0.size() != 0) cur[d] = exp0.pop_front();
        end else begin
          chk("word_expected1", 32'(exp1.size() != 0), 32'd1);
          if (exp1.size() != 0) cur[d] = exp1.pop_front();
        end
      end
      chk($sformatf("frame_start%0d", d), 32'(fs), 32'(idx[d] == 0));
      eb = (idx[d] < 16) ? cur[d][15-idx[d]] : ^cur[d];
      chk($sformatf("bit%0d_%0d", d, idx[d]), 32'(so), 32'(eb));
      idx[d]++;
      lowrun[d] = 0;
      if (idx[d] == len) begin
        idx[d]     = 0;
        lastbit[d] = so;
        ws_exp[d]  = (ws_exp[d] + 1) % 65536;
      end
    end else begin
      chk($sformatf("idle_out%0d", d), 32'(so), 32'd0);
      chk($sformatf("idle_fs%0d", d), 32'(fs), 32'd0);
      chk($sformatf("word_whole%0d", d), 32'(idx[d] == 0), 32'd1);
      idx[d] = 0;
      lowrun[d]++;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    fifo_svc();
    mon(0, if0.ser_valid, if0.ser_out, if0.frame_start, if0.words_sent);
    mon(1, if1.ser_valid, if1.ser_out, if1.frame_start, if1.words_sent);
  endtask

  task automatic push(input int d, input logic [15:0] w);
    if (d == 0) begin
      fq0.push_back(w);
      exp0.push_back(w);
      if0.emptyp = 1'b0;
    end else begin
      fq1.push_back(w);
      exp1.push_back(w);
      if1.emptyp = 1'b0;
    end
  endtask

  initial begin
    logic got;
    int   nv;
    rstn          = 1'b0;
    if0.en        = 1'b1;
    if0.emptyp    = 1'b0;
    if0.fifo_dout = '0;
    if1.en        = 1'b1;
    if1.emptyp    = 1'b0;
    if1.fifo_dout = '0;
    mon_reset();

    // reset held with a live request pending
    repeat (3) tick();
    chk("rst_readp0", 32'(if0.readp), 32'd0);
    chk("rst_valid0", 32'(if0.ser_valid), 32'd0);
    chk("rst_out0", 32'(if0.ser_out), 32'd0);
    chk("rst_busy0", 32'(if0.busy), 32'd0);
    chk("rst_ws0", 32'(if0.words_sent), 32'd0);
    chk("rst_readp1", 32'(if1.readp), 32'd0);
    chk("rst_busy1", 32'(if1.busy), 32'd0);
    if0.en = 1'b0; if1.en = 1'b0;
    if0.emptyp = 1'b1; if1.emptyp = 1'b1;
    tick();
    rstn = 1'b1;
    repeat (2) tick();

    // single word A5C3, latency and completion
    push(0, 16'hA5C3);
    if0.en = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (if0.readp) begin
        got = 1'b1;
        break;
      end
    end
    chk("t3_readp_seen", 32'(got), 32'd1);
    tick();
    chk("t3_readp_pulse", 32'(if0.readp), 32'd0);
    chk("t3_fs_early", 32'(if0.frame_start), 32'd0);
    tick();
    chk("t3_fs_latency", 32'(if0.frame_start), 32'd1);
    for (int i = 0; i < 30 && if0.busy; i++) tick();
    chk("t3_busy_fall", 32'(if0.busy), 32'd0);
    chk("t3_ws", 32'(if0.words_sent), 32'd1);
    chk("t3_sb_empty", exp0.size(), 32'd0);

    // asynchronous reset mid-word
    push(0, 16'hFFFF);
    for (int i = 0; i < 10 && !if0.ser_valid; i++) tick();
    chk("t2_started", 32'(if0.ser_valid), 32'd1);
    repeat (4) tick();
    #2 rstn = 1'b0;
    #1;
    chk("t2_readp", 32'(if0.readp), 32'd0);
    chk("t2_valid", 32'(if0.ser_valid), 32'd0);
    chk("t2_out", 32'(if0.ser_out), 32'd0);
    chk("t2_fs", 32'(if0.frame_start), 32'd0);
    chk("t2_busy", 32'(if0.busy), 32'd0);
    chk("t2_ws", 32'(if0.words_sent), 32'd0);
    fq0.delete(); exp0.delete();
    if0.en = 1'b0; if0.emptyp = 1'b1;
    mon_reset();
    repeat (2) tick();
    rstn = 1'b1;
    tick();

    // empty FIFO with drain enabled
    if0.en = 1'b1;
    rp_cnt[0] = 0;
    repeat (50) tick();
    chk("t4_no_readp", rp_cnt[0], 32'd0);
    chk("t4_busy", 32'(if0.busy), 32'd0);
    chk("t4_valid", 32'(if0.ser_valid), 32'd0);

    // GAP=2 + parity: spacing and parity bit
    if1.en = 1'b1;
    push(1, 16'h0001);
    push(1, 16'h8000);
    for (int i = 0; i < 120 && (exp1.size() != 0 || if1.busy); i++) tick();
    chk("t5_done", 32'(exp1.size() == 0 && !if1.busy), 32'd1);
    chk("t5_gap", lastgap[1], 32'd5);
    chk("t5_ws", 32'(if1.words_sent), 32'd2);
    chk("t5_lastbit", 32'(lastbit[1]), 32'd1);
    push(1, 16'h0003);
    nv = 0;
    for (int i = 0; i < 60 && (exp1.size() != 0 || if1.busy); i++) begin
      tick();
      if (if1.ser_valid) nv++;
    end
    chk("t6_nbits", nv, 32'd17);
    chk("t6_lastbit", 32'(lastbit[1]), 32'd0);
    chk("t6_ws", 32'(if1.words_sent), 32'd3);

    // en dropped at bit 5 with FIFO non-empty
    push(0, 16'h1234);
    push(0, 16'h5678);
    push(0, 16'h9ABC);
    for (int i = 0; i < 20 && idx[0] != 5; i++) tick();
    chk("t7_reached", idx[0], 32'd5);
    if0.en = 1'b0;
    rp_cnt[0] = 0;
    repeat (40) tick();
    chk("t7_no_pop", rp_cnt[0], 32'd0);
    chk("t7_ws", 32'(if0.words_sent), 32'd1);
    chk("t7_busy", 32'(if0.busy), 32'd0);
    chk("t7_left", exp0.size(), 32'd2);
    if0.en = 1'b1;
    for (int i = 0; i < 100 && (exp0.size() != 0 || if0.busy); i++) tick();
    chk("t7_ws2", 32'(if0.words_sent), 32'd3);
    chk("t7_pops", rp_cnt[0], 32'd2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
